// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result drain: FSM encoding, result-set codes
// and the packed FIFO entry width ({set, addr, data}).
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  localparam int unsigned SET_BITS = 2;

  localparam logic [1:0] SET_A = 2'd0;
  localparam logic [1:0] SET_B = 2'd1;
  localparam logic [1:0] SET_C = 2'd2;

  // Bits in one buffered entry: set code, row address and the full row.
  function automatic int unsigned entry_width(input int unsigned array_size,
                                              input int unsigned data_width,
                                              input int unsigned matrix_bits);
    return SET_BITS + matrix_bits + array_size * data_width;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Parameterised FIFO storage for the result drain. DEPTH must be a power of
// two (>= 2) so pointers wrap naturally. The head entry and the count are
// registered; count_next_c exposes the post-update occupancy to the parent.
// Caller guarantees push only when not full (or together with a pop) and
// pop only when non-empty.
module drain_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    srstn,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  count_next_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  // Next storage, pointers, occupancy and head entry.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A push into an empty FIFO lands at rd_ptr_d, so it is visible next cycle.
    head_d = mem_d[rd_ptr_d];
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head         = head_q;
  assign count        = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/tpu_result_drain.sv
// TPU result drain: arbitrates three active-low row-write strobes (a > b > c)
// into a small FIFO and streams rows out with valid/ready, tracking a
// run/flush/done lifecycle and sticky overflow/collision flags.
// Optional: define TPU_DRAIN_CHECKSUM_EN to add a running signed checksum of
// every delivered row element.
module tpu_result_drain
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE        = 8,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned MATRIX_BITS       = 6,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    srstn,
  input  logic                                    sram_write_enable_a0,
  input  logic                                    sram_write_enable_b0,
  input  logic                                    sram_write_enable_c0,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_c,
  input  logic [MATRIX_BITS-1:0]                  sram_waddr_a,
  input  logic [MATRIX_BITS-1:0]                  sram_waddr_b,
  input  logic [MATRIX_BITS-1:0]                  sram_waddr_c,
  input  logic                                    tpu_done,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic [1:0]                              out_set,
  output logic [MATRIX_BITS-1:0]                  out_addr,
  output logic                                    overflow,
  output logic                                    collision,
  output logic                                    drain_done
`ifdef TPU_DRAIN_CHECKSUM_EN
  ,
  output logic [OUTPUT_DATA_WIDTH+7:0]            checksum
`endif
);

  localparam int unsigned ROW_W   = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int unsigned ENTRY_W = entry_width(ARRAY_SIZE, OUTPUT_DATA_WIDTH, MATRIX_BITS);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  logic                   act_a, act_b, act_c;
  logic                   push_req, multi_req;
  logic [1:0]             sel_set;
  logic [MATRIX_BITS-1:0] sel_addr;
  logic [ROW_W-1:0]       sel_data;
  logic [ENTRY_W-1:0]     push_entry;
  logic [ENTRY_W-1:0]     head;
  logic [CW-1:0]          count, count_next;
  logic                   full, pop, push;

  drain_state_e state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic         overflow_q, overflow_d;
  logic         collision_q, collision_d;
  logic         drain_done_q, drain_done_d;

  assign act_a = ~sram_write_enable_a0;
  assign act_b = ~sram_write_enable_b0;
  assign act_c = ~sram_write_enable_c0;

  // Fixed-priority strobe arbitration; a collision is any two strobes at once.
  always_comb begin
    sel_set   = SET_A;
    sel_addr  = sram_waddr_a;
    sel_data  = sram_wdata_a;
    push_req  = act_a | act_b | act_c;
    multi_req = (act_a & act_b) | (act_a & act_c) | (act_b & act_c);
    if (act_a) begin
      sel_set  = SET_A;
      sel_addr = sram_waddr_a;
      sel_data = sram_wdata_a;
    end else if (act_b) begin
      sel_set  = SET_B;
      sel_addr = sram_waddr_b;
      sel_data = sram_wdata_b;
    end else if (act_c) begin
      sel_set  = SET_C;
      sel_addr = sram_waddr_c;
      sel_data = sram_wdata_c;
    end
  end

  assign push_entry = {sel_set, sel_addr, sel_data};
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = out_valid_q & out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push       = push_req & (~full | pop);

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .srstn        (srstn),
    .push         (push),
    .pop          (pop),
    .wdata        (push_entry),
    .head         (head),
    .count        (count),
    .count_next_c (count_next)
  );

  // Lifecycle FSM, sticky flags and registered valid/done.
  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q | (push_req & full & ~pop);
    collision_d  = collision_q | multi_req;
    out_valid_d  = (count_next != '0);
    case (state_q)
      ST_IDLE:  if (push) state_d = ST_RUN;
      ST_RUN:   if (tpu_done) state_d = ST_FLUSH;
      ST_FLUSH: if (count_next == '0) state_d = ST_DONE;
      ST_DONE: begin
        if (push) state_d = ST_FLUSH;
        else if (!tpu_done) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  // Control registers.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      collision_q  <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      collision_q  <= collision_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_set    = head[ENTRY_W-1 -: SET_BITS];
  assign out_addr   = head[ROW_W +: MATRIX_BITS];
  assign out_data   = head[ROW_W-1:0];
  assign overflow   = overflow_q;
  assign collision  = collision_q;
  assign drain_done = drain_done_q;

`ifdef TPU_DRAIN_CHECKSUM_EN
  localparam int unsigned SUM_W = OUTPUT_DATA_WIDTH + 8;

  logic [SUM_W-1:0] checksum_q, checksum_d, row_sum;

  // Signed sum of the head row; accumulated when it is popped.
  always_comb begin
    row_sum = '0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      row_sum = row_sum + SUM_W'($signed(out_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]));
    end
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q + row_sum;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: doc/tpu_result_drain.md
TPU_RESULT_DRAIN -- requirements
Module: tpu_result_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, meaning systolic array dimension.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 16, meaning bits per quantized element.
REQ-003 SHALL have parameter MATRIX_BITS, default 6, meaning result row-address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning buffered entries; power of two, at least 2.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port srstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports sram_write_enable_a0/b0/c0  input  1 each  active-low row-write strobe for result sets 0/1/2.
REQ-008 SHALL have ports sram_wdata_a/b/c  input  ARRAY_SIZE*OUTPUT_DATA_WIDTH each  row data.
REQ-009 SHALL have ports sram_waddr_a/b/c  input  MATRIX_BITS each  row index.
REQ-010 SHALL have port tpu_done  input  1  upstream computation finished (level).
REQ-011 SHALL have ports out_valid  output  1; out_ready  input  1; out_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH; out_set  output  2; out_addr  output  MATRIX_BITS: the result stream.
REQ-012 SHALL have ports overflow  output  1 (sticky, entry lost) and collision  output  1 (sticky, two or more strobes in one cycle).
REQ-013 SHALL have port drain_done  output  1  all results delivered.

Function
REQ-014 SHALL treat a strobe as active when low; an active strobe pushes {set, addr, data} into the FIFO in that cycle.
REQ-015 SHALL encode out_set as a=0, b=1, c=2; value 3 SHALL never be produced.
REQ-016 SHALL, on simultaneous strobes, push only the highest-priority one (a > b > c) and set collision.
REQ-017 SHALL present out_valid high whenever the FIFO is non-empty; out_data, out_set and out_addr SHALL be the head entry and SHALL remain stable while out_valid is high and out_ready is low.
REQ-018 SHALL pop the head on a cycle where out_valid and out_ready are both high.
REQ-019 SHALL provide latency of exactly 1 cycle from strobe edge to out_valid when the FIFO is empty; there SHALL be no combinational path from input to output.
REQ-020 SHALL, when full, accept a push in the same cycle as a pop; when full without a pop, drop the push, keep FIFO contents and set overflow.
REQ-021 SHALL wrap read and write pointers modulo FIFO_DEPTH and use an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-022 SHALL implement an FSM IDLE -> RUN (first push) -> FLUSH (tpu_done high) -> DONE (FIFO empty in FLUSH); DONE -> IDLE when tpu_done drops.
REQ-023 SHALL assert drain_done only in DONE; pushes received in FLUSH or DONE SHALL be accepted, and a push in DONE SHALL return the FSM to FLUSH.
REQ-024 SHALL leave overflow and collision set until reset.

Reset
REQ-025 SHALL, while srstn is low, asynchronously clear the FIFO, pointers and count, and force out_valid=0, out_data=0, out_set=0, out_addr=0, overflow=0, collision=0, drain_done=0 and FSM=IDLE.
REQ-026 SHALL discard buffered entries when reset is asserted mid-operation; the first push after release is treated as a fresh run.

Configuration
REQ-027 SHALL, when TPU_DRAIN_CHECKSUM_EN is defined, add output checksum (OUTPUT_DATA_WIDTH+8 bits) equal to the running wrap-around sum of all signed elements of every popped row, cleared on reset and on the IDLE->RUN transition; when undefined the port and logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-028 SHALL take FSM state encoding, set-code constants (SET_A/B/C) and a FIFO-entry width function from a shared package tpu_pkg.
REQ-029 SHALL instantiate one sub-module, drain_fifo (parameterised storage, pointers and count); arbitration, FSM and flags SHALL stay in the top level.

Verification
REQ-030 SHALL pass: single strobe on a, addr=5, data all 0x0001, out_ready=1 -> one beat next cycle, out_set=0, out_addr=5, FIFO empty after.
REQ-031 SHALL pass: 6 consecutive b strobes, out_ready=0, depth 4 -> 4 entries kept, overflow=1, then out_ready=1 yields addrs 0..3 in order.
REQ-032 SHALL pass: a and c strobed in the same cycle -> only set 0 delivered, collision=1.
REQ-033 SHALL pass: FIFO full, push and pop in the same cycle -> count stays 4, no overflow.
REQ-034 SHALL pass: tpu_done raised with 2 entries queued -> drain_done rises exactly one cycle after the second pop; drops to IDLE when tpu_done falls.
REQ-035 SHALL pass: reset pulse with 3 entries queued -> out_valid=0 immediately, all flags 0, and checksum=0 when TPU_DRAIN_CHECKSUM_EN is defined.
